// File: rtl/pc_epc_unit.sv
// pc_epc_unit: architectural PC / EPC / cause registers with branch qualification
// and a short exception FSM that fetches the handler address byte from a vector.
module pc_epc_unit #(
    parameter int          MEM_LAT    = 1,
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_next,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic [1:0]  branch_op,
    input  logic        alu_zero,
    input  logic        alu_gt,
    input  logic        exc_opcode,
    input  logic        exc_ovf,
    input  logic        exc_div0,
    input  logic [7:0]  exc_mem_byte,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic [1:0]  cause_out,
    output logic        exc_busy,
    output logic        exc_mem_rd,
    output logic [31:0] exc_mem_addr
);
    localparam logic [1:0] IDLE = 2'd0, SAVE = 2'd1, FETCH = 2'd2, LOAD = 2'd3;

    logic [1:0]  state_q, state_d, cnt_q, cnt_d, cause_q, cause_d, exc_cause;
    logic [31:0] pc_q, pc_d, epc_q, epc_d, vec;
    logic        cond, take, any_exc, last;

    always_comb begin
        cond = branch_op == 2'b00 ? alu_zero :
               branch_op == 2'b01 ? ~alu_zero :
               branch_op == 2'b10 ? (alu_zero | ~alu_gt) : (alu_gt & ~alu_zero);
        take = pc_write | (pc_write_cond & cond);
        any_exc = exc_opcode | exc_ovf | exc_div0;
        // div0 outranks overflow, which outranks invalid opcode
        exc_cause = exc_div0 ? 2'b11 : exc_ovf ? 2'b10 : 2'b01;
        last = cnt_q == 2'(MEM_LAT - 1);
        state_d = state_q;
        cnt_d = cnt_q;
        pc_d = pc_q;
        epc_d = epc_q;
        cause_d = cause_q;
        case (state_q)
            IDLE: begin
                if (any_exc) begin
                    state_d = SAVE;
                    cause_d = exc_cause;
                end else if (take) begin
                    pc_d = pc_next;
                end
            end
            SAVE: begin
                epc_d = pc_q - 32'd4;
                state_d = FETCH;
            end
            FETCH: begin
                cnt_d = last ? 2'd0 : cnt_q + 2'd1;
                state_d = last ? LOAD : FETCH;
            end
            default: begin
                pc_d = {24'b0, exc_mem_byte};
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            pc_q <= '0;
            epc_q <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            pc_q <= pc_d;
            epc_q <= epc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        vec = cause_q == 2'b11 ? VEC_DIV0 : cause_q == 2'b10 ? VEC_OVF : VEC_OPCODE;
        exc_busy = state_q != IDLE;
        exc_mem_rd = state_q == FETCH;
        exc_mem_addr = exc_mem_rd ? vec : 32'd0;
        pc_out = pc_q;
        epc_out = epc_q;
        cause_out = cause_q;
    end
endmodule

// File: tb/tb_pc_epc_unit.sv
// tb_pc_epc_unit: drives two instances (MEM_LAT 1 and 3) with shared inputs and
// checks both against a cycle-count reference model of the exception sequence.
module tb_pc_epc_unit;
    logic        clk = 0, reset = 0;
    logic [31:0] pc_next = 0;
    logic        pc_write = 0, pc_write_cond = 0, alu_zero = 0, alu_gt = 0;
    logic [1:0]  branch_op = 0;
    logic        exc_opcode = 0, exc_ovf = 0, exc_div0 = 0;
    logic [7:0]  exc_mem_byte = 0;
    logic [31:0] pc_o [2], epc_o [2], addr_o [2];
    logic [1:0]  cause_o [2];
    logic        busy_o [2], rd_o [2];

    int total = 0, bad = 0;
    int lat [2] = '{1, 3};
    logic [31:0] m_pc [2], m_epc [2];
    logic [1:0]  m_cause [2];
    int          m_t [2];
    int          busy_cnt, rd_cnt;

    always #5 clk = ~clk;

    pc_epc_unit #(.MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
        .alu_gt(alu_gt), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .exc_mem_byte(exc_mem_byte), .pc_out(pc_o[0]), .epc_out(epc_o[0]),
        .cause_out(cause_o[0]), .exc_busy(busy_o[0]), .exc_mem_rd(rd_o[0]),
        .exc_mem_addr(addr_o[0]));

    pc_epc_unit #(.MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .branch_op(branch_op), .alu_zero(alu_zero),
        .alu_gt(alu_gt), .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
        .exc_mem_byte(exc_mem_byte), .pc_out(pc_o[1]), .epc_out(epc_o[1]),
        .cause_out(cause_o[1]), .exc_busy(busy_o[1]), .exc_mem_rd(rd_o[1]),
        .exc_mem_addr(addr_o[1]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit branch_taken();
        case (branch_op)
            2'b00:   return alu_zero;
            2'b01:   return !alu_zero;
            2'b10:   return alu_zero || !alu_gt;
            default: return alu_gt && !alu_zero;
        endcase
    endfunction

    // t counts cycles into an exception: 1 = save, 2..lat+1 = fetch, lat+2 = load
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                m_pc[k] = 0; m_epc[k] = 0; m_cause[k] = 0; m_t[k] = 0;
            end else if (m_t[k] == 0) begin
                if (exc_opcode || exc_ovf || exc_div0) begin
                    m_cause[k] = exc_div0 ? 2'd3 : exc_ovf ? 2'd2 : 2'd1;
                    m_t[k] = 1;
                end else if (pc_write || (pc_write_cond && branch_taken())) begin
                    m_pc[k] = pc_next;
                end
            end else begin
                if (m_t[k] == 1) m_epc[k] = m_pc[k] - 4;
                if (m_t[k] == lat[k] + 2) begin
                    m_pc[k] = {24'b0, exc_mem_byte};
                    m_t[k] = 0;
                end else begin
                    m_t[k]++;
                end
            end
        end
    endtask

    task automatic tick();
        bit rd;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rd = m_t[k] >= 2 && m_t[k] <= lat[k] + 1;
            chk($sformatf("pc%0d", k), pc_o[k], m_pc[k]);
            chk($sformatf("epc%0d", k), epc_o[k], m_epc[k]);
            chk($sformatf("cause%0d", k), 32'(cause_o[k]), 32'(m_cause[k]));
            chk($sformatf("busy%0d", k), 32'(busy_o[k]), 32'(m_t[k] != 0));
            chk($sformatf("rd%0d", k), 32'(rd_o[k]), 32'(rd));
            chk($sformatf("addr%0d", k), addr_o[k], rd ? 32'd252 + 32'(m_cause[k]) : 32'd0);
        end
        busy_cnt += int'(busy_o[0]);
        rd_cnt += int'(rd_o[1]);
    endtask

    task automatic clr();
        pc_write = 0; pc_write_cond = 0; exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
    endtask

    initial begin
        foreach (m_t[k]) begin m_pc[k] = 0; m_epc[k] = 0; m_cause[k] = 0; m_t[k] = 0; end
        reset = 0;
        tick(); tick();
        chk("reset_pc", pc_o[0], 32'd0);
        reset = 1;
        pc_next = 32'h4; pc_write = 1;
        tick();
        clr();
        chk("first_write", pc_o[0], 32'h4);
        chk("first_cause", 32'(cause_o[0]), 32'd0);
        for (int op = 0; op < 4; op++)
            for (int z = 0; z < 2; z++)
                for (int g = 0; g < 2; g++) begin
                    branch_op = 2'(op); alu_zero = z[0]; alu_gt = g[0];
                    pc_write_cond = 1; pc_next = $urandom & 32'hFFFF_FFFC;
                    tick();
                end
        clr();
        pc_next = 32'h40; pc_write = 1;
        tick();
        clr();
        exc_ovf = 1; exc_mem_byte = 8'hA0; busy_cnt = 0; rd_cnt = 0;
        tick();
        clr();
        repeat (7) tick();
        chk("ovf_epc", epc_o[0], 32'h3C);
        chk("ovf_cause", 32'(cause_o[0]), 32'd2);
        chk("ovf_pc", pc_o[0], 32'hA0);
        chk("ovf_busy_cycles", 32'(busy_cnt), 32'd3);
        chk("lat3_rd_cycles", 32'(rd_cnt), 32'd3);
        exc_opcode = 1; exc_div0 = 1; pc_write = 1; pc_next = 32'h1234; exc_mem_byte = 8'h5C;
        tick();
        exc_div0 = 0; pc_next = 32'h999;
        tick(); tick();
        chk("div0_cause", 32'(cause_o[1]), 32'd3);
        chk("div0_addr", addr_o[1], 32'd255);
        chk("div0_pc_kept", pc_o[1], 32'hA0);
        clr();
        reset = 0;
        tick();
        reset = 1;
        chk("midfetch_reset_busy", 32'(busy_o[1]), 32'd0);
        chk("midfetch_reset_pc", pc_o[1], 32'd0);
        exc_opcode = 1; exc_mem_byte = 8'h11;
        tick();
        clr();
        repeat (6) tick();
        chk("wrap_epc0", epc_o[0], 32'hFFFF_FFFC);
        chk("wrap_epc1", epc_o[1], 32'hFFFF_FFFC);
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(31) != 0);
            pc_next = $urandom; pc_write = $urandom_range(3) == 0; pc_write_cond = $urandom_range(1) == 1;
            branch_op = 2'($urandom_range(3)); alu_zero = $urandom_range(1) == 1; alu_gt = $urandom_range(1) == 1;
            exc_opcode = $urandom_range(9) == 0; exc_ovf = $urandom_range(9) == 0; exc_div0 = $urandom_range(9) == 0;
            exc_mem_byte = 8'($urandom);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
